// File: rtl/tank_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tank_pkg                                                                |
// | Shared types and helpers for the tank move arbiter.                     |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
package tank_pkg;

  localparam int MAP_W_DEFAULT = 20;
  localparam int MAP_H_DEFAULT = 15;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD0     = 3'd1,
    S_RD1     = 3'd2,
    S_RESOLVE = 3'd3,
    S_COMMIT  = 3'd4
  } arb_state_t;

  function automatic logic [8:0] tile_idx(input logic [4:0] x, input logic [3:0] y,
                                          input int unsigned map_w);
    return 9'(32'(y) * map_w + 32'(x));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_target_calc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tank_target_calc                                                        |
// | Combinational next-tile step and map bounds check for one tank.         |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tank_target_calc
  import tank_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEFAULT,
  parameter int MAP_H = MAP_H_DEFAULT
) (
  input  logic [4:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic [2:0] dir,
  output logic [4:0] tgt_x,
  output logic [3:0] tgt_y,
  output logic       req,
  output logic       valid
);

  localparam logic [5:0] X_LIM = 6'(MAP_W);
  localparam logic [4:0] Y_LIM = 5'(MAP_H);

  logic [5:0] x_inc;
  logic [4:0] y_inc;
  logic [4:0] step_x;
  logic [3:0] step_y;

  always_comb begin
    x_inc  = {1'b0, cur_x} + 6'd1;
    y_inc  = {1'b0, cur_y} + 5'd1;
    step_x = cur_x;
    step_y = cur_y;
    req    = 1'b1;
    valid  = 1'b0;
    case (dir)
      DIR_UP: begin
        valid  = (cur_y != 4'd0);
        step_y = cur_y - 4'd1;
      end
      DIR_DOWN: begin
        valid  = (y_inc < Y_LIM);
        step_y = y_inc[3:0];
      end
      DIR_LEFT: begin
        valid  = (cur_x != 5'd0);
        step_x = cur_x - 5'd1;
      end
      DIR_RIGHT: begin
        valid  = (x_inc < X_LIM);
        step_x = x_inc[4:0];
      end
      default: req = 1'b0;
    endcase
    // An unusable target collapses onto the current tile
    tgt_x = valid ? step_x : cur_x;
    tgt_y = valid ? step_y : cur_y;
  end

endmodule
`default_nettype wire

// File: rtl/tank_move_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tank_move_arbiter                                                       |
// | Per-frame two-tank move scheduler with wall/tank conflict resolution.   |
// | Optional macro TANK_ARB_FAIR_EN: alternating same-target priority.      |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tank_move_arbiter
  import tank_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEFAULT,
  parameter int MAP_H = MAP_H_DEFAULT,
  parameter int P0_X0 = 1,
  parameter int P0_Y0 = 13,
  parameter int P1_X0 = 18,
  parameter int P1_Y0 = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [2:0] dir0,
  input  logic [2:0] dir1,
  output logic       map_rd,
  output logic [8:0] map_addr,
  input  logic [1:0] map_data,
  output logic [4:0] tank0_x,
  output logic [3:0] tank0_y,
  output logic [4:0] tank1_x,
  output logic [3:0] tank1_y,
  output logic [1:0] blocked,
  output logic       done,
  output logic       busy
);

  arb_state_t state_q, state_d;
  logic [4:0] pos0_x_q, pos0_x_d, pos1_x_q, pos1_x_d;
  logic [3:0] pos0_y_q, pos0_y_d, pos1_y_q, pos1_y_d;
  logic [4:0] tgt0_x_q, tgt0_x_d, tgt1_x_q, tgt1_x_d;
  logic [3:0] tgt0_y_q, tgt0_y_d, tgt1_y_q, tgt1_y_d;
  logic       req0_q, req0_d, req1_q, req1_d;
  logic       val0_q, val0_d, val1_q, val1_d;
  logic       wall0_q, wall0_d;
  logic       mv0_q, mv0_d, mv1_q, mv1_d;
  logic [1:0] blocked_q, blocked_d;
  logic       done_q, done_d;

  logic [4:0] c0_x, c1_x;
  logic [3:0] c0_y, c1_y;
  logic       c0_req, c1_req, c0_val, c1_val;

  logic       prio;
  logic       legal0, legal1, swap, contest, win0, win1, occ0, occ1;

  tank_target_calc #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_calc0 (
    .cur_x(pos0_x_q), .cur_y(pos0_y_q), .dir(dir0),
    .tgt_x(c0_x), .tgt_y(c0_y), .req(c0_req), .valid(c0_val)
  );

  tank_target_calc #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_calc1 (
    .cur_x(pos1_x_q), .cur_y(pos1_y_q), .dir(dir1),
    .tgt_x(c1_x), .tgt_y(c1_y), .req(c1_req), .valid(c1_val)
  );

  // map_data holds wall1 only while in RESOLVE; the results are used only there
  always_comb begin
    legal0  = val0_q & ~wall0_q;
    legal1  = val1_q & ~(|map_data);
    swap    = ({tgt0_x_q, tgt0_y_q} == {pos1_x_q, pos1_y_q}) &&
              ({tgt1_x_q, tgt1_y_q} == {pos0_x_q, pos0_y_q});
    contest = legal0 & legal1 & ({tgt0_x_q, tgt0_y_q} == {tgt1_x_q, tgt1_y_q});
    win0    = legal0 & ~swap & ~(contest & prio);
    win1    = legal1 & ~swap & ~(contest & ~prio);
    occ0    = ({tgt0_x_q, tgt0_y_q} == {pos1_x_q, pos1_y_q}) & ~win1;
    occ1    = ({tgt1_x_q, tgt1_y_q} == {pos0_x_q, pos0_y_q}) & ~win0;
  end

`ifdef TANK_ARB_FAIR_EN
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q ^ ((state_q == S_RESOLVE) & contest);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pos0_x_d  = pos0_x_q;
    pos0_y_d  = pos0_y_q;
    pos1_x_d  = pos1_x_q;
    pos1_y_d  = pos1_y_q;
    tgt0_x_d  = tgt0_x_q;
    tgt0_y_d  = tgt0_y_q;
    tgt1_x_d  = tgt1_x_q;
    tgt1_y_d  = tgt1_y_q;
    req0_d    = req0_q;
    req1_d    = req1_q;
    val0_d    = val0_q;
    val1_d    = val1_q;
    wall0_d   = wall0_q;
    mv0_d     = mv0_q;
    mv1_d     = mv1_q;
    blocked_d = blocked_q;
    done_d    = 1'b0;
    map_rd    = 1'b0;
    map_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          tgt0_x_d = c0_x;
          tgt0_y_d = c0_y;
          tgt1_x_d = c1_x;
          tgt1_y_d = c1_y;
          req0_d   = c0_req;
          req1_d   = c1_req;
          val0_d   = c0_val;
          val1_d   = c1_val;
          state_d  = S_RD0;
        end
      end
      S_RD0: begin
        map_rd   = 1'b1;
        map_addr = tile_idx(tgt0_x_q, tgt0_y_q, MAP_W);
        state_d  = S_RD1;
      end
      S_RD1: begin
        wall0_d  = |map_data;
        map_rd   = 1'b1;
        map_addr = tile_idx(tgt1_x_q, tgt1_y_q, MAP_W);
        state_d  = S_RESOLVE;
      end
      S_RESOLVE: begin
        mv0_d   = win0 & ~occ0;
        mv1_d   = win1 & ~occ1;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (mv0_q) begin
          pos0_x_d = tgt0_x_q;
          pos0_y_d = tgt0_y_q;
        end
        if (mv1_q) begin
          pos1_x_d = tgt1_x_q;
          pos1_y_d = tgt1_y_q;
        end
        blocked_d = {req1_q & ~mv1_q, req0_q & ~mv0_q};
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pos0_x_q  <= 5'(P0_X0);
      pos0_y_q  <= 4'(P0_Y0);
      pos1_x_q  <= 5'(P1_X0);
      pos1_y_q  <= 4'(P1_Y0);
      tgt0_x_q  <= '0;
      tgt0_y_q  <= '0;
      tgt1_x_q  <= '0;
      tgt1_y_q  <= '0;
      req0_q    <= 1'b0;
      req1_q    <= 1'b0;
      val0_q    <= 1'b0;
      val1_q    <= 1'b0;
      wall0_q   <= 1'b0;
      mv0_q     <= 1'b0;
      mv1_q     <= 1'b0;
      blocked_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos0_x_q  <= pos0_x_d;
      pos0_y_q  <= pos0_y_d;
      pos1_x_q  <= pos1_x_d;
      pos1_y_q  <= pos1_y_d;
      tgt0_x_q  <= tgt0_x_d;
      tgt0_y_q  <= tgt0_y_d;
      tgt1_x_q  <= tgt1_x_d;
      tgt1_y_q  <= tgt1_y_d;
      req0_q    <= req0_d;
      req1_q    <= req1_d;
      val0_q    <= val0_d;
      val1_q    <= val1_d;
      wall0_q   <= wall0_d;
      mv0_q     <= mv0_d;
      mv1_q     <= mv1_d;
      blocked_q <= blocked_d;
      done_q    <= done_d;
    end
  end

  assign tank0_x = pos0_x_q;
  assign tank0_y = pos0_y_q;
  assign tank1_x = pos1_x_q;
  assign tank1_y = pos1_y_q;
  assign blocked = blocked_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tank_move_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_tank_move_arbiter                                                    |
// | Directed bench with a frame-level behavioural model of the arbiter.     |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_tank_move_arbiter;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] dir0 = 3'd0;
  logic [2:0] dir1 = 3'd0;
  logic       map_rd;
  logic [8:0] map_addr;
  logic [1:0] map_data = 2'd0;
  logic [4:0] tank0_x, tank1_x;
  logic [3:0] tank0_y, tank1_y;
  logic [1:0] blocked;
  logic       done, busy;

  int checks = 0;
  int failures = 0;
  int mem [0:299];

  // model state: committed view plus the plan for the frame in flight
  int m_x [2] = '{1, 18};
  int m_y [2] = '{13, 1};
  int m_blk = 0;
  int m_done = 0;
  int ph = 0;
  int prio_m = 0;
  int p_x [2];
  int p_y [2];
  int p_addr [2] = '{0, 0};
  bit p_mv [2];
  int p_blk = 0;

  always #5 clk = ~clk;

  tank_move_arbiter #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .P0_X0(1), .P0_Y0(13), .P1_X0(18), .P1_Y0(1)
  ) dut (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .dir0(dir0), .dir1(dir1),
    .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .blocked(blocked), .done(done), .busy(busy)
  );

  always @(posedge clk) begin
    if (map_rd) map_data <= 2'(mem[map_addr]);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic plan();
    int d, dx, dy, nx, ny;
    bit req [2];
    bit valid [2];
    bit legal [2];
    bit mv [2];
    bit keep0, keep1;
    for (int i = 0; i < 2; i++) begin
      d  = (i == 0) ? int'(dir0) : int'(dir1);
      dx = 0;
      dy = 0;
      case (d)
        1: dy = -1;
        2: dy = 1;
        3: dx = -1;
        4: dx = 1;
        default: ;
      endcase
      req[i]    = (dx != 0) || (dy != 0);
      nx        = m_x[i] + dx;
      ny        = m_y[i] + dy;
      valid[i]  = req[i] && nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H;
      p_x[i]    = valid[i] ? nx : m_x[i];
      p_y[i]    = valid[i] ? ny : m_y[i];
      p_addr[i] = p_y[i] * MAP_W + p_x[i];
      legal[i]  = valid[i] && (mem[p_addr[i]] == 0);
    end
    mv = legal;
    if (p_x[0] == m_x[1] && p_y[0] == m_y[1] && p_x[1] == m_x[0] && p_y[1] == m_y[0]) begin
      mv[0] = 1'b0;
      mv[1] = 1'b0;
    end else if (legal[0] && legal[1] && p_x[0] == p_x[1] && p_y[0] == p_y[1]) begin
      if (prio_m == 0) mv[1] = 1'b0;
      else mv[0] = 1'b0;
`ifdef TANK_ARB_FAIR_EN
      prio_m = 1 - prio_m;
`endif
    end
    keep0   = !(p_x[0] == m_x[1] && p_y[0] == m_y[1] && !mv[1]);
    keep1   = !(p_x[1] == m_x[0] && p_y[1] == m_y[0] && !mv[0]);
    p_mv[0] = mv[0] && keep0;
    p_mv[1] = mv[1] && keep1;
    p_blk   = ((req[1] && !p_mv[1]) ? 2 : 0) + ((req[0] && !p_mv[0]) ? 1 : 0);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_x = '{1, 18};
        m_y = '{13, 1};
        m_blk = 0;
        m_done = 0;
        ph = 0;
        prio_m = 0;
      end else begin
        m_done = 0;
        if (ph == 0) begin
          if (frame_tick) begin
            plan();
            ph = 1;
          end
        end else if (ph == 4) begin
          for (int i = 0; i < 2; i++) begin
            if (p_mv[i]) begin
              m_x[i] = p_x[i];
              m_y[i] = p_y[i];
            end
          end
          m_blk = p_blk;
          m_done = 1;
          ph = 0;
        end else begin
          ph++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("tank0_x", 32'(tank0_x), m_x[0]);
    chk("tank0_y", 32'(tank0_y), m_y[0]);
    chk("tank1_x", 32'(tank1_x), m_x[1]);
    chk("tank1_y", 32'(tank1_y), m_y[1]);
    chk("blocked", 32'(blocked), m_blk);
    chk("done", 32'(done), m_done);
    chk("busy", 32'(busy), (ph != 0) ? 1 : 0);
    chk("map_rd", 32'(map_rd), (ph == 1 || ph == 2) ? 1 : 0);
    chk("map_addr", 32'(map_addr), (ph == 1) ? p_addr[0] : (ph == 2) ? p_addr[1] : 0);
  end

  task automatic chk_pos(input string name, input int x0, input int y0, input int x1, input int y1);
    chk({name, "_p0x"}, 32'(tank0_x), x0);
    chk({name, "_p0y"}, 32'(tank0_y), y0);
    chk({name, "_p1x"}, 32'(tank1_x), x1);
    chk({name, "_p1y"}, 32'(tank1_y), y1);
  endtask

  // entered and left one time unit after a rising edge, with the DUT idle
  task automatic do_tick(input logic [2:0] d0, input logic [2:0] d1);
    int lat;
    dir0 = d0;
    dir1 = d1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", 32'(lat), 4);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [2:0] step(input int x, input int y, input int gx, input int gy);
    if (y > gy) return 3'd1;
    if (y < gy) return 3'd2;
    if (x > gx) return 3'd3;
    if (x < gx) return 3'd4;
    return 3'd0;
  endfunction

  task automatic move_to(input int gx0, input int gy0, input int gx1, input int gy1);
    for (int n = 0; n < 40; n++) begin
      if (m_x[0] == gx0 && m_y[0] == gy0 && m_x[1] == gx1 && m_y[1] == gy1) break;
      do_tick(step(m_x[0], m_y[0], gx0, gy0), step(m_x[1], m_y[1], gx1, gy1));
    end
    chk_pos("move_to", gx0, gy0, gx1, gy1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    for (int i = 0; i < 300; i++) mem[i] = 0;
    mem[1 * 20 + 17] = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state and idle frames
    chk_pos("reset", 1, 13, 18, 1);
    chk("reset_blocked", 32'(blocked), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_map_rd", 32'(map_rd), 0);
    chk("reset_map_addr", 32'(map_addr), 0);
    do_tick(3'd0, 3'd0);
    chk_pos("none", 1, 13, 18, 1);
    chk("none_blocked", 32'(blocked), 0);
    do_tick(3'd5, 3'd7);
    chk("dir57_blocked", 32'(blocked), 0);

    // free tile vs wall
    do_tick(3'd4, 3'd3);
    chk_pos("wall", 2, 13, 18, 1);
    chk("wall_blocked", 32'(blocked), 2);

    // same-target contest twice
    reset_dut();
    move_to(4, 5, 6, 5);
    do_tick(3'd4, 3'd3);
    chk_pos("contest1", 5, 5, 6, 5);
    chk("contest1_blocked", 32'(blocked), 2);
    do_tick(3'd3, 3'd0);
    chk_pos("reposition", 4, 5, 6, 5);
    do_tick(3'd4, 3'd3);
`ifdef TANK_ARB_FAIR_EN
    chk_pos("contest2", 4, 5, 5, 5);
    chk("contest2_blocked", 32'(blocked), 1);
`else
    chk_pos("contest2", 5, 5, 6, 5);
    chk("contest2_blocked", 32'(blocked), 2);
`endif

    // swap
    reset_dut();
    move_to(4, 4, 5, 4);
    do_tick(3'd4, 3'd3);
    chk_pos("swap", 4, 4, 5, 4);
    chk("swap_blocked", 32'(blocked), 3);

    // left edge plus read address order
    reset_dut();
    do_tick(3'd3, 3'd0);
    dir0 = 3'd3;
    dir1 = 3'd2;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    chk("edge_addr0", 32'(map_addr), 260);
    chk("edge_rd0", 32'(map_rd), 1);
    @(posedge clk);
    #1;
    chk("edge_addr1", 32'(map_addr), 58);
    repeat (3) @(posedge clk);
    #1;
    chk("edge_done", 32'(done), 1);
    chk_pos("edge", 0, 13, 18, 2);
    chk("edge_blocked", 32'(blocked), 1);

    // reset during RD1 aborts the frame
    dir0 = 3'd0;
    dir1 = 3'd2;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_map_rd", 32'(map_rd), 0);
    chk_pos("abort", 1, 13, 18, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);

    // tick while busy dropped, tick at T+5 accepted
    dir0 = 3'd1;
    dir1 = 3'd0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t5_done", 32'(done), 1);
    chk_pos("t5_first", 1, 12, 18, 1);
    dir0 = 3'd0;
    dir1 = 3'd2;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    chk("t5_busy", 32'(busy), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_done2", 32'(done), 1);
    chk_pos("t5_second", 1, 12, 18, 2);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tank_move_arbiter.md
# tank_move_arbiter

Per-frame move scheduler for the two player tanks. On each frame tick it latches both players' requested directions, reads each target tile from the shared single-port map RAM (one read at a time), resolves tank-vs-wall and tank-vs-tank conflicts, and commits both tile positions atomically. It owns the authoritative tank positions and sits between keycode decode and the map RAM and sprite renderer.

## Interface
Parameters:
- MAP_W, 20, map width in tiles
- MAP_H, 15, map height in tiles
- P0_X0 / P0_Y0, 1 / 13, player 0 reset tile
- P1_X0 / P1_Y0, 18 / 1, player 1 reset tile

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  single-cycle pulse, once per frame
- dir0, dir1  in  3  requested move: 0 none, 1 up, 2 down, 3 left, 4 right; 5–7 treated as none
- map_rd  out  1  map read strobe
- map_addr  out  9  tile index, y*MAP_W+x
- map_data  in  2  tile contents, valid the cycle after map_rd; 0 = free, nonzero = wall
- tank0_x, tank1_x  out  5  tile column
- tank0_y, tank1_y  out  4  tile row
- blocked  out  2  per-player: last requested move was refused
- done  out  1  one-cycle pulse on commit
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- States: IDLE, RD0, RD1, RESOLVE, COMMIT.
- IDLE: on frame_tick, latch dir0/dir1 and compute target tiles with ±1 steps. Up decrements y.
- A target is invalid if the direction is none, or if the target is out of bounds (x<0, x≥MAP_W, y<0, y≥MAP_H). An invalid target is set to the current tile.
- IDLE → RD0.
- RD0: map_rd=1, map_addr=target0. → RD1.
- RD1: capture wall0 from map_data. map_rd=1, map_addr=target1. → RESOLVE.
- RESOLVE: capture wall1. A player's move is legal iff the target is valid and its wall flag is 0. Then apply these rules in order:
  - Swap: the two targets equal each other's current tiles → both refused.
  - Same target: both legal and equal → the priority player moves, the other is refused. Priority then toggles.
  - Occupied: a target equals the other tank's current tile and the other tank is not legally leaving → that move is refused.
- COMMIT: update positions and blocked. done=1. → IDLE.
- No-move (dir none) is never flagged blocked.
- frame_tick while busy is ignored; the request is not queued.
- Priority register resets to player 0.
- Reset values:
  - positions = parameter reset tiles
  - blocked = 0, done = 0, busy = 0, map_rd = 0, map_addr = 0
  - state = IDLE
- Reset mid-sequence aborts with no commit.

## Timing
- frame_tick sampled high in IDLE at cycle T.
- RD0 at T+1, RD1 at T+2, RESOLVE at T+3, COMMIT at T+4.
- New positions and blocked are visible from T+5, the same cycle done pulses registered. done is registered out of COMMIT.
- busy is high T+1..T+4.
- The next accepted tick is T+5 at the earliest.
- map_rd is high exactly in RD0 and RD1. Only one map read is outstanding at a time.
- Outputs hold between commits.

## Configuration
- TANK_ARB_FAIR_EN defined: same-target priority alternates as described.
- Not defined: player 0 always wins a same-target contest, and the priority register is removed.

## Structure
- Shared package tank_pkg:
  - dir_t enum (NONE, UP, DOWN, LEFT, RIGHT)
  - arb_state_t
  - MAP_W and MAP_H defaults
  - tile_idx function (y*MAP_W+x)
- One sub-module, tank_target_calc: combinational next-tile and bounds check, instantiated once per player.

## Test plan
- Reset, then a tick with both dirs none → positions (1,13)/(18,1), done at T+5, blocked=00.
- P0 right into a free tile, P1 left into a wall (map[1*20+17]=1) → P0 at (2,13), P1 stays at (18,1), blocked=10 (bit1 set).
- Both tanks adjacent to tile (5,5) and both target it, repeated over two ticks (reposition between) → first tick P0 wins; second tick P1 wins with FAIR_EN and P0 wins without it.
- Tanks at (4,4)/(5,4), P0 right, P1 left → swap, both blocked, positions unchanged.
- P0 at (0,13) moving left → stays put, blocked[0]=1. Also check that the map_addr sequence is 260 then P1's target.
- Reset asserted at RD1 → immediate IDLE, reset positions restored, no done pulse.
- A tick issued at T+2 is ignored; a tick at T+5 is accepted.
